// File: rtl/commit_stage.sv
// Pipe-6 commit stage: retires integer/CSR write-backs, prioritises traps and xRETs,
// and holds the pipeline in a short flush window after any redirect.
module commit_stage #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        valid5,
  input  logic        we5,
  input  logic [4:0]  rd5,
  input  logic [31:0] result5,
  input  logic        csr_we5,
  input  logic [11:0] csr_addr5,
  input  logic [31:0] csr_wdata5,
  input  logic [31:0] pc5,
  input  logic        instruction_addr_misaligned5,
  input  logic        illegal_instr5,
  input  logic        ecall5,
  input  logic        mret5,
  input  logic        sret5,
  input  logic        uret5,
  input  logic [1:0]  current_mode,
  input  logic        irq_m,
  input  logic        irq_s,
  input  logic        irq_u,
  output logic        we6,
  output logic [4:0]  rdaddr6,
  output logic [31:0] wb6,
  output logic        csr_we6,
  output logic [11:0] csr_wb_addr,
  output logic [31:0] csr_wb,
  output logic        exception_pending,
  output logic [31:0] cause,
  output logic [31:0] pc_exc,
  output logic        m_ret,
  output logic        s_ret,
  output logic        u_ret,
  output logic        m_interrupt,
  output logic        s_interrupt,
  output logic        u_interrupt,
  output logic        exception
);

  typedef enum logic [1:0] {StRun, StTrap, StFlush} state_e;

  state_e     state;
  logic [2:0] fcnt;

  logic        take_trap;
  logic        take_ret;
  logic [31:0] trap_cause;
  logic [31:0] ecall_cause;

  // Reserved mode 2'b10 is handled as machine mode.
  always_comb begin
    ecall_cause = 32'd11;
    case (current_mode)
      2'b00:   ecall_cause = 32'd8;
      2'b01:   ecall_cause = 32'd9;
      default: ecall_cause = 32'd11;
    endcase
  end

  always_comb begin
    take_trap  = 1'b1;
    trap_cause = '0;
    if (irq_m)                             trap_cause = 32'h8000_000B;
    else if (irq_s)                        trap_cause = 32'h8000_0009;
    else if (irq_u)                        trap_cause = 32'h8000_0008;
    else if (instruction_addr_misaligned5) trap_cause = 32'd0;
    else if (illegal_instr5)               trap_cause = 32'd2;
    else if (ecall5)                       trap_cause = ecall_cause;
    else                                   take_trap  = 1'b0;
    take_ret = mret5 | sret5 | uret5;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state             <= StRun;
      fcnt              <= '0;
      we6               <= 1'b0;
      rdaddr6           <= '0;
      wb6               <= '0;
      csr_we6           <= 1'b0;
      csr_wb_addr       <= '0;
      csr_wb            <= '0;
      exception_pending <= 1'b0;
      cause             <= '0;
      pc_exc            <= '0;
      m_ret             <= 1'b0;
      s_ret             <= 1'b0;
      u_ret             <= 1'b0;
      m_interrupt       <= 1'b0;
      s_interrupt       <= 1'b0;
      u_interrupt       <= 1'b0;
      exception         <= 1'b0;
    end else begin
      // Enables and pulses default low; data/address registers hold.
      we6               <= 1'b0;
      csr_we6           <= 1'b0;
      exception_pending <= 1'b0;
      cause             <= '0;
      pc_exc            <= '0;
      m_ret             <= 1'b0;
      s_ret             <= 1'b0;
      u_ret             <= 1'b0;
      m_interrupt       <= 1'b0;
      s_interrupt       <= 1'b0;
      u_interrupt       <= 1'b0;
      unique case (state)
        StRun: begin
          exception <= 1'b0;
          if (valid5) begin
            if (take_trap) begin
              exception_pending <= 1'b1;
              cause             <= trap_cause;
              pc_exc            <= pc5;
              m_interrupt       <= irq_m;
              s_interrupt       <= !irq_m && irq_s;
              u_interrupt       <= !irq_m && !irq_s && irq_u;
              exception         <= 1'b1;
              state             <= StTrap;
            end else if (take_ret) begin
              m_ret     <= mret5;
              s_ret     <= !mret5 && sret5;
              u_ret     <= !mret5 && !sret5 && uret5;
              exception <= 1'b1;
              state     <= StTrap;
            end else begin
              if (we5 && (rd5 != 5'd0)) begin
                we6     <= 1'b1;
                rdaddr6 <= rd5;
                wb6     <= result5;
              end
              if (csr_we5) begin
                csr_we6     <= 1'b1;
                csr_wb_addr <= csr_addr5;
                csr_wb      <= csr_wdata5;
              end
            end
          end
        end
        StTrap: begin
          exception <= 1'b1;
          fcnt      <= 3'(FLUSH_CYCLES);
          state     <= StFlush;
        end
        StFlush: begin
          if (fcnt == 3'd1) begin
            exception <= 1'b0;
            fcnt      <= '0;
            state     <= StRun;
          end else begin
            exception <= 1'b1;
            fcnt      <= fcnt - 3'd1;
          end
        end
        default: begin
          exception <= 1'b0;
          fcnt      <= '0;
          state     <= StRun;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_commit_stage.sv
// Scoreboard bench for commit_stage: each driven cycle queues the expected output
// image, and a monitor compares it against the DUT just after the following edge.
module tb_commit_stage;

  typedef struct packed {
    logic        we6;
    logic [4:0]  rdaddr6;
    logic [31:0] wb6;
    logic        csr_we6;
    logic [11:0] csr_wb_addr;
    logic [31:0] csr_wb;
    logic        pend;
    logic [31:0] cause;
    logic [31:0] pc_exc;
    logic        m_ret;
    logic        s_ret;
    logic        u_ret;
    logic        m_int;
    logic        s_int;
    logic        u_int;
    logic        exc;
  } out_t;

  logic        clk = 1'b0;
  logic        nrst;
  logic        valid5, we5, csr_we5;
  logic [4:0]  rd5;
  logic [31:0] result5, csr_wdata5, pc5;
  logic [11:0] csr_addr5;
  logic        mis5, ill5, ecall5, mret5, sret5, uret5;
  logic [1:0]  current_mode;
  logic        irq_m, irq_s, irq_u;

  out_t act;
  out_t h;

  out_t  exp_q[$];
  string lbl_q[$];
  int    checks   = 0;
  int    failures = 0;

  commit_stage #(.FLUSH_CYCLES(2)) dut (
    .clk                          (clk),
    .nrst                         (nrst),
    .valid5                       (valid5),
    .we5                          (we5),
    .rd5                          (rd5),
    .result5                      (result5),
    .csr_we5                      (csr_we5),
    .csr_addr5                    (csr_addr5),
    .csr_wdata5                   (csr_wdata5),
    .pc5                          (pc5),
    .instruction_addr_misaligned5 (mis5),
    .illegal_instr5               (ill5),
    .ecall5                       (ecall5),
    .mret5                        (mret5),
    .sret5                        (sret5),
    .uret5                        (uret5),
    .current_mode                 (current_mode),
    .irq_m                        (irq_m),
    .irq_s                        (irq_s),
    .irq_u                        (irq_u),
    .we6                          (act.we6),
    .rdaddr6                      (act.rdaddr6),
    .wb6                          (act.wb6),
    .csr_we6                      (act.csr_we6),
    .csr_wb_addr                  (act.csr_wb_addr),
    .csr_wb                       (act.csr_wb),
    .exception_pending            (act.pend),
    .cause                        (act.cause),
    .pc_exc                       (act.pc_exc),
    .m_ret                        (act.m_ret),
    .s_ret                        (act.s_ret),
    .u_ret                        (act.u_ret),
    .m_interrupt                  (act.m_int),
    .s_interrupt                  (act.s_int),
    .u_interrupt                  (act.u_int),
    .exception                    (act.exc)
  );

  always #5 clk = ~clk;

  // Monitor: one expected image per edge, sampled 1ns after the edge.
  initial begin
    out_t  e;
    string l;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        l = lbl_q.pop_front();
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL %s: got %h expected %h", l, act, e);
        end
      end
    end
  end

  task automatic clr_in();
    valid5 = 0; we5 = 0; rd5 = 0; result5 = 0; csr_we5 = 0; csr_addr5 = 0;
    csr_wdata5 = 0; pc5 = 0; mis5 = 0; ill5 = 0; ecall5 = 0; mret5 = 0;
    sret5 = 0; uret5 = 0; current_mode = 2'b11; irq_m = 0; irq_s = 0; irq_u = 0;
  endtask

  // Clear enables, pulses and trap info; data/address fields keep their held values.
  task automatic quiet();
    h.we6 = 0; h.csr_we6 = 0; h.pend = 0; h.cause = 0; h.pc_exc = 0;
    h.m_ret = 0; h.s_ret = 0; h.u_ret = 0; h.m_int = 0; h.s_int = 0; h.u_int = 0;
    h.exc = 0;
  endtask

  task automatic step(input string lbl);
    exp_q.push_back(h);
    lbl_q.push_back(lbl);
    @(negedge clk);
  endtask

  task automatic retire(input logic [4:0] rd, input logic [31:0] res, input string lbl);
    clr_in();
    valid5 = 1; we5 = 1; rd5 = rd; result5 = res;
    quiet();
    if (rd != 0) begin
      h.we6 = 1; h.rdaddr6 = rd; h.wb6 = res;
    end
    step(lbl);
  endtask

  // Three wrong-path instructions after a redirect: two discarded under exception=1,
  // the third discarded as the flush ends.
  task automatic flush3(input string lbl);
    for (int i = 0; i < 3; i++) begin
      clr_in();
      valid5 = 1; we5 = 1; rd5 = 5'd31; result5 = 32'hBAD0_0000 + i;
      csr_we5 = 1; csr_addr5 = 12'h7FF; csr_wdata5 = 32'hBAD;
      quiet();
      h.exc = (i < 2);
      step($sformatf("%s_flush%0d", lbl, i));
    end
  endtask

  task automatic expect_trap(input logic [31:0] c, input logic [31:0] pc);
    quiet();
    h.pend = 1; h.cause = c; h.pc_exc = pc; h.exc = 1;
  endtask

  initial begin
    h = '0;
    clr_in();
    nrst = 0;
    @(negedge clk);
    step("reset0");
    step("reset1");
    nrst = 1;

    retire(5'd5, 32'hDEAD_BEEF, "retire_rd5");
    retire(5'd0, 32'h1234_5678, "retire_rd0");

    clr_in();
    valid5 = 1; we5 = 1; rd5 = 5'd3; result5 = 32'h1800;
    csr_we5 = 1; csr_addr5 = 12'h300; csr_wdata5 = 32'h8;
    quiet();
    h.we6 = 1; h.rdaddr6 = 5'd3; h.wb6 = 32'h1800;
    h.csr_we6 = 1; h.csr_wb_addr = 12'h300; h.csr_wb = 32'h8;
    step("csr_op");

    clr_in();
    irq_m = 1;
    quiet();
    step("irq_no_valid");

    clr_in();
    valid5 = 1; ecall5 = 1; current_mode = 2'b00; pc5 = 32'h100;
    we5 = 1; rd5 = 5'd7; result5 = 32'h77; csr_we5 = 1; csr_addr5 = 12'h305;
    csr_wdata5 = 32'h55;
    expect_trap(32'd8, 32'h100);
    step("ecall_u");
    flush3("ecall_u");
    retire(5'd13, 32'hD, "after_flush");

    clr_in();
    valid5 = 1; irq_s = 1; ill5 = 1; pc5 = 32'h200; we5 = 1; rd5 = 5'd1;
    expect_trap(32'h8000_0009, 32'h200);
    h.s_int = 1;
    step("irq_s_over_illegal");
    flush3("irq_s");

    clr_in();
    valid5 = 1; mret5 = 1; sret5 = 1;
    quiet();
    h.m_ret = 1; h.exc = 1;
    step("mret_over_sret");
    flush3("mret");

    clr_in();
    valid5 = 1; irq_m = 1; irq_s = 1; ecall5 = 1; pc5 = 32'h240;
    expect_trap(32'h8000_000B, 32'h240);
    h.m_int = 1;
    step("irq_m_top");
    flush3("irq_m");

    clr_in();
    valid5 = 1; irq_u = 1; mret5 = 1; pc5 = 32'h260;
    expect_trap(32'h8000_0008, 32'h260);
    h.u_int = 1;
    step("irq_u_over_mret");
    flush3("irq_u");

    clr_in();
    valid5 = 1; mis5 = 1; ill5 = 1; pc5 = 32'h280;
    expect_trap(32'd0, 32'h280);
    step("misaligned_over_illegal");
    flush3("mis");

    clr_in();
    valid5 = 1; ill5 = 1; ecall5 = 1; pc5 = 32'h2A0;
    expect_trap(32'd2, 32'h2A0);
    step("illegal_over_ecall");
    flush3("ill");

    clr_in();
    valid5 = 1; ecall5 = 1; current_mode = 2'b10; pc5 = 32'h2C0;
    expect_trap(32'd11, 32'h2C0);
    step("ecall_mode10");
    flush3("ecall10");

    clr_in();
    valid5 = 1; sret5 = 1; uret5 = 1;
    quiet();
    h.s_ret = 1; h.exc = 1;
    step("sret_over_uret");
    flush3("sret");

    clr_in();
    valid5 = 1; uret5 = 1;
    quiet();
    h.u_ret = 1; h.exc = 1;
    step("uret");
    flush3("uret");

    retire(5'd1, 32'h11, "b2b_0");
    retire(5'd2, 32'h22, "b2b_1");
    retire(5'd3, 32'h33, "b2b_2");

    // Reset during the second flush cycle.
    clr_in();
    valid5 = 1; ecall5 = 1; current_mode = 2'b01; pc5 = 32'h400;
    expect_trap(32'd9, 32'h400);
    step("ecall_s");
    clr_in();
    valid5 = 1; we5 = 1; rd5 = 5'd4; result5 = 32'h44;
    quiet(); h.exc = 1;
    step("rst_trap_cycle");
    quiet(); h.exc = 1;
    step("rst_flush1");
    nrst = 0;
    h = '0;
    step("rst_mid_flush");
    nrst = 1;
    clr_in();
    valid5 = 1; we5 = 1; rd5 = 5'd9; result5 = 32'h99;
    csr_we5 = 1; csr_addr5 = 12'h341; csr_wdata5 = 32'hABC;
    quiet();
    h.we6 = 1; h.rdaddr6 = 5'd9; h.wb6 = 32'h99;
    h.csr_we6 = 1; h.csr_wb_addr = 12'h341; h.csr_wb = 32'hABC;
    step("retire_after_reset");

    clr_in();
    quiet();
    step("idle_hold");

    repeat (2) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/commit_stage.md
# commit_stage

Final pipeline stage (pipe 6) of the in-order RV32 core. Samples the retiring instruction from execute/memory, then drives the issue stage's integer and CSR regfile write-back ports. Also prioritises exceptions, interrupts and xRETs, and drives trap/return information into the CSR file. After any redirect it runs a flush FSM that raises `exception` to the scoreboard/frontend and discards wrong-path instructions.

## Interface
- FLUSH_CYCLES, 2, cycles spent in FLUSH after TRAP; legal range 1..7.

- clk  in  1  clock, rising edge
- nrst  in  1  reset, synchronous, active-low
- valid5  in  1  stage-5 slot holds a real instruction
- we5  in  1  instruction writes rd
- rd5  in  5  destination register
- result5  in  32  rd write data (ALU/mem/old CSR value)
- csr_we5  in  1  instruction writes a CSR
- csr_addr5  in  12  CSR address
- csr_wdata5  in  32  CSR write data
- pc5  in  32  instruction PC
- instruction_addr_misaligned5, illegal_instr5, ecall5  in  1 each  exception flags
- mret5, sret5, uret5  in  1 each  xRET flags
- current_mode  in  2  privilege: U=00, S=01, M=11
- irq_m, irq_s, irq_u  in  1 each  pending-and-enabled interrupt requests
- we6  out  1  integer regfile write enable
- rdaddr6  out  5  write address
- wb6  out  32  write data
- csr_we6  out  1  CSR write enable
- csr_wb_addr  out  12  CSR write address
- csr_wb  out  32  CSR write data
- exception_pending  out  1  one-cycle trap pulse to CSR file
- cause  out  32  mcause value, valid with exception_pending
- pc_exc  out  32  trapping PC, valid with exception_pending
- m_ret, s_ret, u_ret  out  1 each  one-cycle xRET pulses
- m_interrupt, s_interrupt, u_interrupt  out  1 each  one-cycle interrupt-taken pulses
- exception  out  1  flush request to scoreboard/frontend

## Operation
- FSM states: RUN, TRAP, FLUSH. The 3-bit counter `fcnt` is used only in FLUSH.
- All outputs are registered. Inputs are evaluated only when the state is RUN and valid5=1; in TRAP and FLUSH, inputs are ignored.
- Event priority, highest first:
  - irq_m: cause 0x8000000B
  - irq_s: cause 0x80000009
  - irq_u: cause 0x80000008
  - instruction_addr_misaligned5: cause 0
  - illegal_instr5: cause 2
  - ecall5: cause 8 + current_mode, giving 8 (U), 9 (S), 11 (M); current_mode=10 is treated as M
  - mret5, then sret5, then uret5
- Trap (any interrupt or exception):
  - next cycle: exception_pending=1, cause set, pc_exc=pc5, matching x_interrupt pulse for interrupts, exception=1
  - we6=0 and csr_we6=0: the trapping instruction does not retire
  - state goes to TRAP
- xRET:
  - next cycle: the single matching x_ret pulse, exception=1, no writes, exception_pending=0
  - state goes to TRAP
  - if more than one xRET flag is set, only the highest-priority one pulses
- Normal retire, next cycle:
  - we6 = we5 & (rd5!=0); rdaddr6=rd5; wb6=result5
  - csr_we6=csr_we5; csr_wb_addr=csr_addr5; csr_wb=csr_wdata5
- TRAP always transitions to FLUSH with fcnt=FLUSH_CYCLES. FLUSH decrements fcnt each cycle; when fcnt==1 the next state is RUN.
- exception=1 in TRAP and FLUSH, 0 in RUN. All write enables and pulse outputs are 0 in TRAP and FLUSH.
- When an output enable is 0, its data/address outputs hold their last values. Exception: cause and pc_exc are zeroed whenever exception_pending=0.
- irq_* with valid5=0 is not taken; it waits for the next valid instruction.

## Timing
- Retire latency is 1 cycle: inputs sampled at edge E appear on outputs after E.
- Trap/xRET sampled at edge E0:
  - exception_pending / x_ret pulses are high for the cycle after E0 only
  - exception is high for exactly 1+FLUSH_CYCLES cycles
  - inputs at edges E1 through E(1+FLUSH_CYCLES) are discarded
  - the first accepted edge is E(2+FLUSH_CYCLES)
- Back-to-back retires with valid5=1 every cycle produce one write per cycle with no bubbles.
- Reset (nrst=0 at an edge), including mid-TRAP/FLUSH, results after that edge in:
  - state RUN, fcnt=0
  - every output 0: we6, rdaddr6, wb6, csr_we6, csr_wb_addr, csr_wb, exception_pending, cause, pc_exc, all x_ret and x_interrupt pulses, exception
  - inputs at the first edge with nrst=1 are evaluated normally

## Test plan
- Retire we5=1, rd5=5, result5=0xDEADBEEF; then rd5=0 with we5=1 -> first: we6=1, rdaddr6=5, wb6=0xDEADBEEF one cycle later; second: we6=0.
- CSR op: csr_we5=1, csr_addr5=0x300, csr_wdata5=0x8, we5=1, rd5=3, result5=0x1800 -> same cycle: csr_we6=1, csr_wb_addr=0x300, csr_wb=0x8, we6=1, wb6=0x1800.
- ecall5 in current_mode=00 at pc5=0x100, with we5=1 and csr_we5=1, followed by 4 valid instructions (FLUSH_CYCLES=2):
  - exception_pending=1, cause=8, pc_exc=0x100, no writes
  - exception high 3 cycles
  - next 3 instructions discarded; the 4th retires
- irq_s=1 together with illegal_instr5=1 at pc5=0x200 -> cause=0x80000009, s_interrupt=1, pc_exc=0x200; the illegal instruction is not reported.
- mret5=1 together with sret5=1 -> m_ret=1 for one cycle, s_ret=0, exception_pending=0, exception high 3 cycles.
- nrst=0 asserted during the second FLUSH cycle -> after the edge: all outputs 0, state RUN; a valid retire presented in the next cycle writes normally.
